// File: rtl/pong_pkg.sv
// Shared types, default geometry and helpers for the Pong game engine slice.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    // Wide enough that ball and paddle bounds never wrap when offset.
    typedef logic signed [13:0] coord_t;

    localparam int H_RES_DEF     = 800;
    localparam int V_RES_DEF     = 600;
    localparam int BALL_SIZE_DEF = 16;
    localparam int PADDLE_W_DEF  = 16;
    localparam int PADDLE_H_DEF  = 80;
    localparam int PADDLE_XL_DEF = 20;
    localparam int PADDLE_XR_DEF = 764;

    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/pong_if.sv
// Game-engine signal bundle: frame/player inputs in, ball and score state out.
interface pong_if;

    logic        vblnk_in;
    logic        mouse_left;
    logic [1:0]  difficulty;
    logic [11:0] ypos_l;
    logic [11:0] ypos_r;
    logic [11:0] ball_x;
    logic [11:0] ball_y;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic [2:0]  state;
    logic        hit_pulse;
    logic        game_over;

    modport master (
        input  vblnk_in, mouse_left, difficulty, ypos_l, ypos_r,
        output ball_x, ball_y, score_l, score_r, state, hit_pulse, game_over
    );

    modport slave (
        output vblnk_in, mouse_left, difficulty, ypos_l, ypos_r,
        input  ball_x, ball_y, score_l, score_r, state, hit_pulse, game_over
    );

endinterface

// File: rtl/pong_ball_step.sv
// Combinational one-frame ball advance: wall bounces, paddle hits and misses.
module pong_ball_step
    import pong_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int BALL_SIZE  = BALL_SIZE_DEF,
    parameter int PADDLE_W   = PADDLE_W_DEF,
    parameter int PADDLE_H   = PADDLE_H_DEF,
    parameter int PADDLE_XL  = PADDLE_XL_DEF,
    parameter int PADDLE_XR  = PADDLE_XR_DEF,
    parameter int TWO_PLAYER = 0
) (
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic        vx_neg,
    input  logic        vy_neg,
    input  logic [3:0]  speed,
    input  logic [11:0] ypos_l,
    input  logic [11:0] ypos_r,
    output logic [11:0] next_x,
    output logic [11:0] next_y,
    output logic        next_vx_neg,
    output logic        next_vy_neg,
    output logic        hit,
    output logic        miss_l,
    output logic        miss_r
);

    localparam bit     TP        = (TWO_PLAYER != 0);
    localparam coord_t C_ZERO    = '0;
    localparam coord_t C_XMAX    = coord_t'(H_RES - BALL_SIZE);
    localparam coord_t C_YMAX    = coord_t'(V_RES - BALL_SIZE);
    localparam coord_t C_LEDGE   = coord_t'(PADDLE_XL + PADDLE_W);
    localparam coord_t C_RSTOP   = coord_t'(PADDLE_XR - BALL_SIZE);
    localparam coord_t C_BS      = coord_t'(BALL_SIZE);
    localparam coord_t C_HALF_BS = coord_t'(BALL_SIZE / 2);
    localparam coord_t C_PH      = coord_t'(PADDLE_H);
    localparam coord_t C_HALF_PH = coord_t'(PADDLE_H / 2);

    coord_t sp, cx, cy, nx, ny, yl, yr;
    logic   bounce_top, bounce_bot, ovl_l, ovl_r, hit_l, hit_r, upper_l, upper_r;

    assign sp = coord_t'({10'd0, speed});
    assign cx = coord_t'({2'b00, x});
    assign cy = coord_t'({2'b00, y});
    assign yl = coord_t'({2'b00, ypos_l});
    assign yr = coord_t'({2'b00, ypos_r});
    assign nx = vx_neg ? cx - sp : cx + sp;
    assign ny = vy_neg ? cy - sp : cy + sp;

    assign bounce_top = (ny <= C_ZERO);
    assign bounce_bot = !bounce_top && (ny >= C_YMAX);

    assign ovl_l   = (ny + C_BS > yl) && (ny < yl + C_PH);
    assign ovl_r   = (ny + C_BS > yr) && (ny < yr + C_PH);
    assign upper_l = (ny + C_HALF_BS < yl + C_HALF_PH);
    assign upper_r = (ny + C_HALF_BS < yr + C_HALF_PH);

    assign hit_l  = vx_neg && (nx <= C_LEDGE) && ovl_l;
    assign hit_r  = TP && !vx_neg && (nx >= C_RSTOP) && ovl_r;
    assign hit    = hit_l || hit_r;
    assign miss_l = !hit && (nx <= C_ZERO);
    assign miss_r = TP && !hit && (nx >= C_XMAX);

    assign next_x = hit_l            ? C_LEDGE[11:0] :
                    hit_r            ? C_RSTOP[11:0] :
                    (nx <= C_ZERO)   ? 12'd0         :
                    (nx >= C_XMAX)   ? C_XMAX[11:0]  : nx[11:0];

    // Right wall only reflects in single-player; a two-player overrun is a miss.
    assign next_vx_neg = hit_l          ? 1'b0 :
                         hit_r          ? 1'b1 :
                         miss_l         ? 1'b1 :
                         miss_r         ? 1'b0 :
                         (nx >= C_XMAX) ? 1'b1 : vx_neg;

    assign next_y = bounce_top ? 12'd0 :
                    bounce_bot ? C_YMAX[11:0] : ny[11:0];

    // A wall bounce in the same frame as a hit keeps the ball heading off the wall.
    assign next_vy_neg = bounce_top ? 1'b0 :
                         bounce_bot ? 1'b1 :
                         hit_l      ? upper_l :
                         hit_r      ? upper_r : vy_neg;

endmodule

// File: rtl/pong_game_engine.sv
// Frame-rate Pong engine: serve sequencing, scoring and game-over around pong_ball_step.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int BALL_SIZE    = BALL_SIZE_DEF,
    parameter int PADDLE_W     = PADDLE_W_DEF,
    parameter int PADDLE_H     = PADDLE_H_DEF,
    parameter int PADDLE_XL    = PADDLE_XL_DEF,
    parameter int PADDLE_XR    = PADDLE_XR_DEF,
    parameter int TWO_PLAYER   = 0,
    parameter int MAX_SCORE    = 9,
    parameter int MAX_SPEED    = 8,
    parameter int SERVE_FRAMES = 60
) (
    input logic   pclk,
    input logic   rst,
    pong_if.master bus
);

    localparam int          CNT_W      = $clog2(SERVE_FRAMES + 1);
    localparam logic [11:0] CENTRE_X   = 12'((H_RES - BALL_SIZE) / 2);
    localparam logic [11:0] CENTRE_Y   = 12'((V_RES - BALL_SIZE) / 2);
    localparam logic [3:0]  MAX_SC     = 4'(MAX_SCORE);
    localparam logic [3:0]  MAX_SPD    = 4'(MAX_SPEED);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_t           state;
    logic [11:0]      ball_x, ball_y, step_x, step_y;
    logic [3:0]       score_l, score_r, speed, base_speed;
    logic [CNT_W-1:0] serve_cnt;
    logic             vx_neg, vy_neg, hit_pulse, game_over;
    logic             vblnk_d, mouse_d, tick, press;
    logic             step_vx_neg, step_vy_neg, step_hit, step_miss_l, step_miss_r;

    assign tick       = bus.vblnk_in & ~vblnk_d;
    assign press      = bus.mouse_left & ~mouse_d;
    assign base_speed = {2'b00, bus.difficulty} + 4'd1;

    pong_ball_step #(
        .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BALL_SIZE),
        .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H),
        .PADDLE_XL(PADDLE_XL), .PADDLE_XR(PADDLE_XR), .TWO_PLAYER(TWO_PLAYER)
    ) u_step (
        .x(ball_x), .y(ball_y), .vx_neg(vx_neg), .vy_neg(vy_neg), .speed(speed),
        .ypos_l(bus.ypos_l), .ypos_r(bus.ypos_r),
        .next_x(step_x), .next_y(step_y),
        .next_vx_neg(step_vx_neg), .next_vy_neg(step_vy_neg),
        .hit(step_hit), .miss_l(step_miss_l), .miss_r(step_miss_r)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            ball_x    <= CENTRE_X;
            ball_y    <= CENTRE_Y;
            score_l   <= '0;
            score_r   <= '0;
            speed     <= 4'd1;
            vx_neg    <= 1'b0;
            vy_neg    <= 1'b0;
            serve_cnt <= '0;
            hit_pulse <= 1'b0;
            game_over <= 1'b0;
            vblnk_d   <= 1'b0;
            mouse_d   <= 1'b0;
        end else begin
            vblnk_d   <= bus.vblnk_in;
            mouse_d   <= bus.mouse_left;
            hit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        ball_x  <= CENTRE_X;
                        ball_y  <= CENTRE_Y;
                        score_l <= '0;
                        score_r <= '0;
                        speed   <= base_speed;
                    end
                    if (press) begin
                        state     <= SERVE;
                        serve_cnt <= '0;
                        vx_neg    <= 1'b0;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        ball_x <= CENTRE_X;
                        ball_y <= CENTRE_Y;
                        speed  <= base_speed;
                        if (serve_cnt == SERVE_LAST)
                            state <= PLAY;
                        else
                            serve_cnt <= serve_cnt + CNT_W'(1);
                    end
                end
                PLAY: begin
                    if (tick) begin
                        ball_x <= step_x;
                        ball_y <= step_y;
                        vx_neg <= step_vx_neg;
                        vy_neg <= step_vy_neg;
                        if (step_hit) begin
                            hit_pulse <= 1'b1;
                            if (speed < MAX_SPD)
                                speed <= speed + 4'd1;
                        end
                        if (step_miss_l) begin
                            score_r <= sat_inc(score_r, MAX_SC);
                            state   <= POINT;
                        end else if (step_miss_r) begin
                            score_l <= sat_inc(score_l, MAX_SC);
                            state   <= POINT;
                        end
                    end
                end
                POINT: begin
                    if (score_l == MAX_SC || score_r == MAX_SC) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        state     <= SERVE;
                        serve_cnt <= '0;
                        ball_x    <= CENTRE_X;
                        ball_y    <= CENTRE_Y;
                    end
                end
                OVER: begin
                    if (press) begin
                        state     <= IDLE;
                        score_l   <= '0;
                        score_r   <= '0;
                        game_over <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ball_x    = ball_x;
    assign bus.ball_y    = ball_y;
    assign bus.score_l   = score_l;
    assign bus.score_r   = score_r;
    assign bus.state     = state;
    assign bus.hit_pulse = hit_pulse;
    assign bus.game_over = game_over;

endmodule

// File: tb/tb_pong_game_engine.sv
// Drives a wall-side engine and a two-paddle engine side by side against a frame-level reference model.
module tb_pong_game_engine;

    localparam int SF     = 60;
    localparam int MAXSPD = 8;
    localparam int CX     = 392;
    localparam int CY     = 292;
    localparam int XMAX   = 784;
    localparam int YMAX   = 584;
    localparam int LEDGE  = 36;
    localparam int RSTOP  = 748;

    typedef struct packed {
        int st;
        int x;
        int y;
        int sl;
        int sr;
        int dx;
        int dy;
        int spd;
        int cnt;
        bit hit;
        bit over;
        bit vd;
        bit md;
    } mdl_t;

    logic        pclk = 1'b0;
    logic        rst, vblnk, mouse;
    logic [1:0]  diff;
    logic [11:0] yl_a, yl_b, yr_b;
    int          tests = 0;
    int          fails = 0;
    mdl_t        ma, mb;

    pong_if bus_a ();
    pong_if bus_b ();

    assign bus_a.vblnk_in   = vblnk;
    assign bus_a.mouse_left = mouse;
    assign bus_a.difficulty = diff;
    assign bus_a.ypos_l     = yl_a;
    assign bus_a.ypos_r     = yr_b;
    assign bus_b.vblnk_in   = vblnk;
    assign bus_b.mouse_left = mouse;
    assign bus_b.difficulty = diff;
    assign bus_b.ypos_l     = yl_b;
    assign bus_b.ypos_r     = yr_b;

    pong_game_engine #(.TWO_PLAYER(0), .MAX_SCORE(2)) dut_a (.pclk(pclk), .rst(rst), .bus(bus_a));
    pong_game_engine #(.TWO_PLAYER(1), .MAX_SCORE(3)) dut_b (.pclk(pclk), .rst(rst), .bus(bus_b));

    always #5 pclk = ~pclk;

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = 0; m.x = CX; m.y = CY; m.sl = 0; m.sr = 0;
        m.dx = 1; m.dy = 1; m.spd = 1; m.cnt = 0;
        m.hit = 0; m.over = 0; m.vd = 0; m.md = 0;
        return m;
    endfunction

    // One frame of ball flight using signed velocities and plain integer geometry.
    function automatic mdl_t play(mdl_t m, int yl, int yr, bit tp, int maxs);
        mdl_t n = m;
        int nx = m.x + m.dx * m.spd;
        int ny = m.y + m.dy * m.spd;
        bit bounced = 1;
        if (ny <= 0) begin n.y = 0; n.dy = 1; end
        else if (ny >= YMAX) begin n.y = YMAX; n.dy = -1; end
        else begin n.y = ny; bounced = 0; end
        if (m.dx < 0 && nx <= LEDGE && ny + 16 > yl && ny < yl + 80) begin
            n.x = LEDGE; n.dx = 1; n.hit = 1;
            n.spd = (m.spd < MAXSPD) ? m.spd + 1 : MAXSPD;
            if (!bounced) n.dy = (ny + 8 < yl + 40) ? -1 : 1;
        end else if (tp && m.dx > 0 && nx + 16 >= 764 && ny + 16 > yr && ny < yr + 80) begin
            n.x = RSTOP; n.dx = -1; n.hit = 1;
            n.spd = (m.spd < MAXSPD) ? m.spd + 1 : MAXSPD;
            if (!bounced) n.dy = (ny + 8 < yr + 40) ? -1 : 1;
        end else if (nx <= 0) begin
            n.x = 0; n.dx = -1; n.st = 3;
            n.sr = (m.sr < maxs) ? m.sr + 1 : maxs;
        end else if (nx >= XMAX) begin
            n.x = XMAX;
            if (tp) begin
                n.dx = 1; n.st = 3;
                n.sl = (m.sl < maxs) ? m.sl + 1 : maxs;
            end else begin
                n.dx = -1;
            end
        end else begin
            n.x = nx;
        end
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit vb, bit ml, int d, int yl, int yr, bit tp, int maxs);
        mdl_t n = m;
        bit tick = vb && !m.vd;
        bit press = ml && !m.md;
        n.vd = vb; n.md = ml; n.hit = 0;
        case (m.st)
            0: begin
                if (tick) begin n.x = CX; n.y = CY; n.sl = 0; n.sr = 0; n.spd = d + 1; end
                if (press) begin n.st = 1; n.cnt = 0; n.dx = 1; end
            end
            1: if (tick) begin
                n.x = CX; n.y = CY; n.spd = d + 1;
                if (m.cnt == SF - 1) n.st = 2;
                else n.cnt = m.cnt + 1;
            end
            2: if (tick) n = play(n, yl, yr, tp, maxs);
            3: if (m.sl == maxs || m.sr == maxs) begin
                n.st = 4; n.over = 1;
            end else begin
                n.st = 1; n.cnt = 0; n.x = CX; n.y = CY;
            end
            4: if (press) begin n.st = 0; n.sl = 0; n.sr = 0; n.over = 0; end
            default: n = m;
        endcase
        return n;
    endfunction

    function automatic int track(int y);
        int v;
        if ($urandom_range(0, 5) == 0) return int'($urandom_range(0, 520));
        v = y - 60 + int'($urandom_range(0, 70));
        return (v < 0) ? 0 : v;
    endfunction

    task automatic checkField(input string tag, input logic [15:0] obs, input int expv);
        tests++;
        assert (obs === 16'(expv))
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string who, input mdl_t m,
                               input logic [11:0] bx, input logic [11:0] by,
                               input logic [3:0] sl, input logic [3:0] sr,
                               input logic [2:0] st, input logic hp, input logic go);
        checkField({who, ".ball_x"},    16'(bx), m.x);
        checkField({who, ".ball_y"},    16'(by), m.y);
        checkField({who, ".score_l"},   16'(sl), m.sl);
        checkField({who, ".score_r"},   16'(sr), m.sr);
        checkField({who, ".state"},     16'(st), m.st);
        checkField({who, ".hit_pulse"}, 16'(hp), int'(m.hit));
        checkField({who, ".game_over"}, 16'(go), int'(m.over));
    endtask

    task automatic applyStimulus(input bit r, input bit vb, input bit ml, input int d,
                                 input int yla, input int ylb, input int yrb);
        @(negedge pclk);
        rst = r; vblnk = vb; mouse = ml; diff = 2'(d);
        yl_a = 12'(yla); yl_b = 12'(ylb); yr_b = 12'(yrb);
        if (r) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, vb, ml, d, yla, yrb, 1'b0, 2);
            mb = mstep(mb, vb, ml, d, ylb, yrb, 1'b1, 3);
        end
        @(posedge pclk);
        #1;
        checkOutput("a", ma, bus_a.ball_x, bus_a.ball_y, bus_a.score_l, bus_a.score_r,
                    bus_a.state, bus_a.hit_pulse, bus_a.game_over);
        checkOutput("b", mb, bus_b.ball_x, bus_b.ball_y, bus_b.score_l, bus_b.score_r,
                    bus_b.state, bus_b.hit_pulse, bus_b.game_over);
    endtask

    task automatic frame(input bit ml, input int d, input int yla, input int ylb, input int yrb);
        applyStimulus(1'b0, 1'b1, ml, d, yla, ylb, yrb);
        repeat (3) applyStimulus(1'b0, 1'b0, ml, d, yla, ylb, yrb);
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b0; mouse = 1'b0; diff = 2'd0;
        yl_a = '0; yl_b = '0; yr_b = '0;
        ma = mreset(); mb = mreset();

        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        frame(1'b0, 0, 0, 0, 0);
        checkField("reset_state",   16'(bus_a.state),     0);
        checkField("reset_ball_x",  16'(bus_a.ball_x),    392);
        checkField("reset_ball_y",  16'(bus_a.ball_y),    292);
        checkField("reset_score_l", 16'(bus_a.score_l),   0);
        checkField("reset_score_r", 16'(bus_a.score_r),   0);
        checkField("reset_over",    16'(bus_a.game_over), 0);

        frame(1'b1, 1, 300, 300, 300);
        repeat (SF) frame(1'b0, 1, 300, 300, 300);
        checkField("serve_done_a", 16'(bus_a.state), 2);
        checkField("serve_done_b", 16'(bus_b.state), 2);
        frame(1'b0, 1, 300, 300, 300);
        checkField("first_step_x", 16'(bus_a.ball_x), 394);
        checkField("first_step_y", 16'(bus_a.ball_y), 294);

        for (int f = 0; f < 3000; f++)
            frame($urandom_range(0, 9) == 0, int'($urandom_range(0, 3)),
                  track(ma.y), track(mb.y), track(mb.y));

        applyStimulus(1'b1, 1'b0, 1'b0, 3, 0, 0, 0);
        frame(1'b0, 3, 1000, 300, 300);
        frame(1'b1, 3, 1000, 300, 300);
        for (int i = 0; i < 3000 && ma.st != 4; i++)
            frame(1'b0, 3, 1000, track(mb.y), track(mb.y));
        checkField("over_state",   16'(bus_a.state),     4);
        checkField("over_flag",    16'(bus_a.game_over), 1);
        checkField("over_score_r", 16'(bus_a.score_r),   2);

        frame(1'b1, 3, 1000, 300, 300);
        checkField("restart_state",   16'(bus_a.state),     0);
        checkField("restart_score_r", 16'(bus_a.score_r),   0);
        checkField("restart_over",    16'(bus_a.game_over), 0);

        frame(1'b0, 2, 300, 300, 300);
        frame(1'b1, 2, 300, 300, 300);
        for (int i = 0; i < 200 && ma.st != 2; i++)
            frame(1'b0, 2, 300, 300, 300);
        frame(1'b0, 2, 300, 300, 300);
        checkField("play_before_rst", 16'(bus_a.state), 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 2, 300, 300, 300);
        checkField("rst_in_play_state",  16'(bus_a.state),  0);
        checkField("rst_in_play_ball_x", 16'(bus_a.ball_x), 392);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
